io_bus_ctrl: RTL and testbench
==============================

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 SHALL have parameter NUM_DEV, default 4, number of peripheral channels (legal range 1..8).
REQ-002 SHALL have parameter DEV_BASE, default {32'hF0000004,32'hF0000000,32'hE0000000,32'h00000000}, packed NUM_DEV x 32 region base; channel 0 is in the LSBs.
REQ-003 SHALL have parameter DEV_MASK, default {32'hFFFFFFFC,32'hFFFFFFFC,32'hF0000000,32'hFFFFF000}, packed NUM_DEV x 32 compare mask.
REQ-004 SHALL have parameter DEV_WAIT, default 16'h0010, packed NUM_DEV x 4 wait states per channel.
REQ-005 SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles allowed without an ack.
REQ-006 Ports: clk  in  1  the only clock; rising edge.
REQ-007 Ports: rst  in  1  reset; synchronous and active-high.
REQ-008 Ports: cpu_req  in  1  access request; the CPU holds it and all cpu_* inputs stable until cpu_ready.
REQ-009 Ports: cpu_we  in  1  1 means write, 0 means read.
REQ-010 Ports: cpu_addr  in  32  byte address.
REQ-011 Ports: cpu_wdata  in  32  write data.
REQ-012 Ports: cpu_rdata  out  32  read data, valid while cpu_ready is high.
REQ-013 Ports: cpu_ready  out  1  one-cycle completion pulse.
REQ-014 Ports: cpu_err  out  1  error flag, qualified by cpu_ready.
REQ-015 Ports: dev_sel  out  NUM_DEV  one-hot channel select.
REQ-016 Ports: dev_we  out  NUM_DEV  per-channel write strobe.
REQ-017 Ports: dev_addr  out  32  latched address.
REQ-018 Ports: dev_wdata  out  32  latched write data.
REQ-019 Ports: dev_rdata  in  NUM_DEV x 32  packed per-channel read data.
REQ-020 Ports: dev_ack  in  NUM_DEV  per-channel completion.
REQ-021 Ports: err_addr  out  32  address of the most recent failed access.

Function
REQ-022 Channel i SHALL hit when (cpu_addr & DEV_MASK[i]) == (DEV_BASE[i] & DEV_MASK[i]); on multiple hits the lowest index SHALL win.
REQ-023 The FSM SHALL have the states IDLE, WAIT, ACCESS and RESP.
REQ-024 In IDLE with cpu_req high and a hit, the block SHALL latch addr, wdata, we and the channel index, then go to WAIT (loading the counter with DEV_WAIT[i]-1) if DEV_WAIT[i] is nonzero, otherwise go to ACCESS.
REQ-025 In IDLE with cpu_req high and no hit, the block SHALL go to RESP with err=1, rdata=32'hDEADBEEF and err_addr=cpu_addr.
REQ-026 WAIT SHALL last exactly DEV_WAIT[i] cycles with dev_sel all zero, then go to ACCESS.
REQ-027 In ACCESS, dev_sel[i] SHALL be 1 and dev_we[i] SHALL equal the latched we.
REQ-028 In ACCESS, dev_ack[i] high SHALL capture dev_rdata[i] (reads only; writes return 0) and go to RESP with err=0.
REQ-029 dev_ack on non-selected channels SHALL be ignored.
REQ-030 A timeout counter SHALL clear on entry to ACCESS; after TIMEOUT ACCESS cycles without dev_ack[i], the block SHALL go to RESP with err=1, rdata=32'hDEADBEEF and err_addr set to the latched address.
REQ-031 In RESP, cpu_ready SHALL be 1 for exactly one cycle, and the block SHALL then go to IDLE.
REQ-032 cpu_ready, cpu_err and cpu_rdata SHALL be registered outputs.
REQ-033 cpu_req SHALL be ignored outside IDLE; a request held through RESP SHALL start a new access on the cycle after RESP (no combinational re-accept).
REQ-034 Latency: with req in cycle 0, a hit and ack on the first ACCESS cycle, cpu_ready SHALL be asserted in cycle W+2, where W = DEV_WAIT[i].
REQ-035 dev_addr and dev_wdata SHALL hold the latched values from the accept edge until the next accept.

Reset
REQ-036 rst sampled high SHALL force the IDLE state, all counters to 0, cpu_ready=0, cpu_err=0, cpu_rdata=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0 and err_addr=0 on that edge.
REQ-037 rst asserted mid-access (in WAIT, ACCESS or RESP) SHALL abort the access with no cpu_ready pulse.

Structure
REQ-038 Package io_bus_pkg SHALL hold the state encoding, the constant BUS_ERR_DATA=32'hDEADBEEF and the width constants.
REQ-039 A combinational sub-module io_addr_decoder SHALL produce the hit flag and the priority index from the address, DEV_BASE and DEV_MASK.

Verification
REQ-040 Read 32'hF0000000 (ch2, W=1), with dev_ack[2] and dev_rdata[2]=32'h12345678 on the first ACCESS cycle -> cpu_ready in cycle 3, rdata=32'h12345678, err=0.
REQ-041 Write 32'hE0000010 (ch1, W=0), wdata=32'hA5 -> dev_sel=4'b0010 and dev_we=4'b0010 in cycle 1; cpu_ready in cycle 2.
REQ-042 Read 32'h80000000 (no hit) -> cpu_ready in cycle 1 with err=1, rdata=32'hDEADBEEF and err_addr=32'h80000000; dev_sel stays 0.
REQ-043 Access ch0 with dev_ack[0] held low -> err=1 after 16 ACCESS cycles, err_addr equal to the access address, dev_sel deasserted in RESP.
REQ-044 Assert rst while in WAIT on ch3 -> all outputs at their reset values on the next cycle; no cpu_ready pulse.
REQ-045 Back-to-back: hold cpu_req high for two reads to ch3 -> two cpu_ready pulses separated by exactly one IDLE cycle; a stray dev_ack[1] pulse has no effect.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the CPU-to-peripheral bus controller.
package io_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WAIT_W = 4;
    localparam int IDX_W  = 3;

    // Returned on the CPU side whenever an access fails (decode miss or timeout).
    localparam logic [DATA_W-1:0] BUS_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/io_addr_decoder.sv
// Address decoder: flags a hit and returns the lowest-numbered matching channel.
module io_addr_decoder
    import io_bus_pkg::*;
#(
    parameter int                        NUM_DEV  = 4,
    parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE = '0,
    parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    // Scan from the highest channel down so the lowest matching index is the last write.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if ((i_addr & DEV_MASK[i*ADDR_W +: ADDR_W]) ==
                (DEV_BASE[i*ADDR_W +: ADDR_W] & DEV_MASK[i*ADDR_W +: ADDR_W])) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// CPU-to-peripheral bus controller: decodes the CPU address, inserts per-channel
// wait states, runs the access with a timeout, and returns a one-cycle response.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int                        NUM_DEV  = 4,
    parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE = {32'hF0000004, 32'hF0000000, 32'hE0000000, 32'h00000000},
    parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK = {32'hFFFFFFFC, 32'hFFFFFFFC, 32'hF0000000, 32'hFFFFF000},
    parameter logic [NUM_DEV*WAIT_W-1:0] DEV_WAIT = 16'h0010,
    parameter int                        TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_ready,
    output logic                      cpu_err,
    output logic [NUM_DEV-1:0]        dev_sel,
    output logic [NUM_DEV-1:0]        dev_we,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]        dev_ack,
    output logic [ADDR_W-1:0]         err_addr
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic [WAIT_W-1:0]  w_wait;
    logic               w_ack;
    logic [DATA_W-1:0]  w_rdata;

    state_t             r_state;
    logic               r_we;
    logic [IDX_W-1:0]   r_idx;
    logic [WAIT_W-1:0]  r_wcnt;
    logic [TO_W-1:0]    r_tcnt;
    logic [NUM_DEV-1:0] r_sel;
    logic [NUM_DEV-1:0] r_dev_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [ADDR_W-1:0]  r_err_addr;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_ready;
    logic               r_err;

    function automatic logic [NUM_DEV-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (idx == IDX_W'(i)) onehot[i] = 1'b1;
        end
    endfunction

    io_addr_decoder #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_dec (
        .i_addr (cpu_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    // Per-channel muxes: wait count for the decoded channel, ack/rdata for the latched one.
    always_comb begin
        w_wait  = '0;
        w_ack   = 1'b0;
        w_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (w_idx == IDX_W'(i)) w_wait = DEV_WAIT[i*WAIT_W +: WAIT_W];
            if (r_idx == IDX_W'(i)) begin
                w_ack   = dev_ack[i];
                w_rdata = dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Access sequencer with registered CPU and device-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wcnt     <= '0;
            r_tcnt     <= '0;
            r_sel      <= '0;
            r_dev_we   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err_addr <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (w_hit) begin
                            r_addr  <= cpu_addr;
                            r_wdata <= cpu_wdata;
                            r_we    <= cpu_we;
                            r_idx   <= w_idx;
                            if (w_wait != '0) begin
                                r_wcnt  <= w_wait - WAIT_W'(1);
                                r_state <= ST_WAIT;
                            end else begin
                                r_tcnt   <= '0;
                                r_sel    <= onehot(w_idx);
                                r_dev_we <= cpu_we ? onehot(w_idx) : '0;
                                r_state  <= ST_ACCESS;
                            end
                        end else begin
                            r_ready    <= 1'b1;
                            r_err      <= 1'b1;
                            r_rdata    <= BUS_ERR_DATA;
                            r_err_addr <= cpu_addr;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_tcnt   <= '0;
                        r_sel    <= onehot(r_idx);
                        r_dev_we <= r_we ? onehot(r_idx) : '0;
                        r_state  <= ST_ACCESS;
                    end else begin
                        r_wcnt <= r_wcnt - WAIT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    if (w_ack) begin
                        r_sel    <= '0;
                        r_dev_we <= '0;
                        r_ready  <= 1'b1;
                        r_err    <= 1'b0;
                        r_rdata  <= r_we ? '0 : w_rdata;
                        r_state  <= ST_RESP;
                    end else if (r_tcnt == TO_W'(TIMEOUT - 1)) begin
                        r_sel      <= '0;
                        r_dev_we   <= '0;
                        r_ready    <= 1'b1;
                        r_err      <= 1'b1;
                        r_rdata    <= BUS_ERR_DATA;
                        r_err_addr <= r_addr;
                        r_state    <= ST_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready = r_ready;
    assign cpu_err   = r_err;
    assign cpu_rdata = r_rdata;
    assign dev_sel   = r_sel;
    assign dev_we    = r_dev_we;
    assign dev_addr  = r_addr;
    assign dev_wdata = r_wdata;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed and randomized bench for io_bus_ctrl with a transaction-level reference model.
module tb_io_bus_ctrl;

    localparam int           NUM_DEV = 4;
    localparam logic [127:0] BASE    = {32'hF0000004, 32'hF0000000, 32'hE0000000, 32'h00000000};
    localparam logic [127:0] MASK    = {32'hFFFFFFFC, 32'hFFFFFFFC, 32'hF0000000, 32'hFFFFF000};
    // ch0=0, ch1=0, ch2=1, ch3=2 wait states: gives ch2 one wait and ch3 a WAIT phase to reset into.
    localparam logic [15:0]  WAITS   = 16'h2100;
    localparam int           TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cpu_req;
    logic                 cpu_we;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [31:0]          cpu_rdata;
    logic                 cpu_ready;
    logic                 cpu_err;
    logic [NUM_DEV-1:0]   dev_sel;
    logic [NUM_DEV-1:0]   dev_we;
    logic [31:0]          dev_addr;
    logic [31:0]          dev_wdata;
    logic [NUM_DEV*32-1:0] dev_rdata;
    logic [NUM_DEV-1:0]   dev_ack;
    logic [31:0]          err_addr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_err_addr;
    logic [31:0] m_dev_addr;
    logic [31:0] m_dev_wdata;

    always #5 clk = ~clk;

    io_bus_ctrl #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (BASE),
        .DEV_MASK (MASK),
        .DEV_WAIT (WAITS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .dev_sel   (dev_sel),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack),
        .err_addr  (err_addr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: first channel whose masked base matches the masked address.
    function automatic int model_ch(input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] m;
        for (int i = 0; i < NUM_DEV; i++) begin
            b = BASE[i*32 +: 32];
            m = MASK[i*32 +: 32];
            if ((a & m) == (b & m)) return i;
        end
        return -1;
    endfunction

    function automatic int model_wait(input int ch);
        logic [15:0] w;
        w = WAITS;
        return int'(w[ch*4 +: 4]);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"},    32'(cpu_ready), 32'h0);
        check({tag, ".err"},      32'(cpu_err),   32'h0);
        check({tag, ".rdata"},    cpu_rdata,      32'h0);
        check({tag, ".sel"},      32'(dev_sel),   32'h0);
        check({tag, ".we"},       32'(dev_we),    32'h0);
        check({tag, ".addr"},     dev_addr,       32'h0);
        check({tag, ".wdata"},    dev_wdata,      32'h0);
        check({tag, ".err_addr"}, err_addr,       32'h0);
    endtask

    // One CPU transaction. Cycle 0 is the cycle in which cpu_req is presented.
    // ack_at = ACCESS cycle (1-based) on which the target acks; 0 = never acks.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_at, input bit stray, input bit hold);
        int               ch;
        int               w;
        int               exp_lat;
        int               c;
        int               limit;
        logic [31:0]      exp_rd;
        logic             exp_err;
        logic [NUM_DEV-1:0] oh;
        logic [NUM_DEV-1:0] sel_seen;
        logic [NUM_DEV-1:0] we_seen;
        logic [NUM_DEV-1:0] a;

        ch       = model_ch(addr);
        w        = (ch >= 0) ? model_wait(ch) : 0;
        oh       = '0;
        sel_seen = '0;
        we_seen  = '0;
        if (ch < 0) begin
            exp_lat = 1;
            exp_err = 1'b1;
            exp_rd  = 32'hDEADBEEF;
        end else begin
            oh[ch] = 1'b1;
            if (ack_at >= 1 && ack_at <= TIMEOUT) begin
                exp_lat = w + 1 + ack_at;
                exp_err = 1'b0;
                exp_rd  = we ? 32'h0 : dev_rdata[ch*32 +: 32];
            end else begin
                exp_lat = w + 1 + TIMEOUT;
                exp_err = 1'b1;
                exp_rd  = 32'hDEADBEEF;
            end
            m_dev_addr  = addr;
            m_dev_wdata = wdata;
        end
        if (exp_err) m_err_addr = addr;

        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        dev_ack   = '0;
        c         = 0;
        limit     = exp_lat + 4;
        do begin
            step();
            c++;
            a = stray ? NUM_DEV'($urandom) : '0;
            if (ch >= 0) a[ch] = (ack_at >= 1 && c == w + ack_at);
            dev_ack = a;
            if (ch >= 0 && c == w + 1) begin
                sel_seen = dev_sel;
                we_seen  = dev_we;
            end
        end while (!cpu_ready && c < limit);

        check({tag, ".latency"},  32'(c),          32'(exp_lat));
        check({tag, ".ready"},    32'(cpu_ready),  32'h1);
        check({tag, ".err"},      32'(cpu_err),    32'(exp_err));
        check({tag, ".rdata"},    cpu_rdata,       exp_rd);
        check({tag, ".err_addr"}, err_addr,        m_err_addr);
        check({tag, ".sel_resp"}, 32'(dev_sel),    32'h0);
        check({tag, ".we_resp"},  32'(dev_we),     32'h0);
        check({tag, ".dev_addr"}, dev_addr,        m_dev_addr);
        check({tag, ".dev_wdata"}, dev_wdata,      m_dev_wdata);
        if (ch >= 0) begin
            check({tag, ".sel_access"}, 32'(sel_seen), 32'(oh));
            check({tag, ".we_access"},  32'(we_seen),  we ? 32'(oh) : 32'h0);
        end

        dev_ack = '0;
        if (!hold) cpu_req = 1'b0;
        step();
        check({tag, ".one_pulse"}, 32'(cpu_ready), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sel;
        int          ak;
        int          ready_seen;
        logic [31:0] addr;

        rst         = 1'b1;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        dev_rdata   = '0;
        dev_ack     = '0;
        m_err_addr  = '0;
        m_dev_addr  = '0;
        m_dev_wdata = '0;

        repeat (2) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        dev_rdata = {$urandom, $urandom, $urandom, $urandom};
        dev_rdata[2*32 +: 32] = 32'h12345678;
        txn("rd_ch2", 1'b0, 32'hF0000000, 32'h0, 1, 1'b0, 1'b0);
        txn("wr_ch1", 1'b1, 32'hE0000010, 32'h000000A5, 1, 1'b0, 1'b0);
        txn("miss",   1'b0, 32'h80000000, 32'h0, 1, 1'b0, 1'b0);
        txn("tmo_ch0", 1'b0, 32'h00000040, 32'h0, 0, 1'b1, 1'b0);

        dev_rdata[3*32 +: 32] = 32'hCAFE0003;
        txn("b2b_a", 1'b0, 32'hF0000004, 32'h0, 2, 1'b1, 1'b1);
        txn("b2b_b", 1'b0, 32'hF0000004, 32'h0, 1, 1'b1, 1'b0);

        // Reset while the ch3 access is sitting in its wait states.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'hF0000004;
        step();
        rst     = 1'b1;
        cpu_req = 1'b0;
        step();
        check_reset_outputs("rst_wait");
        rst         = 1'b0;
        m_err_addr  = '0;
        m_dev_addr  = '0;
        m_dev_wdata = '0;
        ready_seen  = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_ready) ready_seen++;
        end
        check("rst_wait.no_ready", 32'(ready_seen), 32'h0);
        txn("post_rst", 1'b1, 32'hF0000006, 32'h0BADF00D, 1, 1'b0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       addr = {20'h0, 12'($urandom)};
                1:       addr = {4'hE, 28'($urandom)};
                2:       addr = 32'hF0000000 | 32'($urandom_range(0, 3));
                3:       addr = 32'hF0000004 | 32'($urandom_range(0, 3));
                default: addr = $urandom;
            endcase
            ak = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            dev_rdata = {$urandom, $urandom, $urandom, $urandom};
            txn($sformatf("rnd%0d", k), 1'($urandom), addr, $urandom, ak, 1'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
